fight_health: RTL and testbench

FIGHT_HEALTH -- requirements
Module: fight_health

---
 rtl/fight_health.sv | 205 ++++++++++++++++++++
 tb/tb_fight_health.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fight_health.sv
// Two-player fighting-game health tracker: hp, invulnerability frames, KO hold and round sequencing.
// Optional macro DRAW_EN: a simultaneous double KO reports a draw instead of awarding P1.
module fight_health #(
    parameter int unsigned MAX_HP  = 100,
    parameter int unsigned DAMAGE  = 10,
    parameter int unsigned IFRAMES = 30,
    parameter int unsigned KO_HOLD = 120
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       hitP1,
    input  logic       hitP2,
    output logic [7:0] p1_hp,
    output logic [7:0] p2_hp,
    output logic       p1_stun,
    output logic       p2_stun,
    output logic       fighting,
    output logic       ko,
    output logic       round_over,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FIGHT   = 2'd1,
        S_KO_HOLD = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [7:0] L_MAX_HP  = 8'(MAX_HP);
    localparam logic [7:0] L_DAMAGE  = 8'(DAMAGE);
    localparam logic [7:0] L_IFRAMES = 8'(IFRAMES);
    localparam logic [9:0] L_KO_LAST = 10'(KO_HOLD - 1);

`ifdef DRAW_EN
    localparam logic [1:0] L_DOUBLE_KO_WINNER = 2'b11;
    localparam logic       L_RESTORE_P1       = 1'b0;
`else
    localparam logic [1:0] L_DOUBLE_KO_WINNER = 2'b01;
    localparam logic       L_RESTORE_P1       = 1'b1;
`endif

    state_t     r_state;
    state_t     w_stateNext;
    logic [7:0] r_p1Hp;
    logic [7:0] r_p2Hp;
    logic [7:0] r_p1Stun;
    logic [7:0] r_p2Stun;
    logic [9:0] r_koCnt;
    logic [1:0] r_winner;

    logic       w_reload;
    logic       w_p1Zero;
    logic       w_p2Zero;
    logic       w_anyZero;
    logic       w_koEnter;
    logic       w_koDone;
    logic       w_p1Hit;
    logic       w_p2Hit;
    logic [7:0] w_p1HpHit;
    logic [7:0] w_p2HpHit;
    logic [1:0] w_koWinner;

    // KO is detected from the registered hp, so ko rises one frame after the lethal hit;
    // hits are frozen in that frame so both players' results are final when the winner latches.
    assign w_reload  = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    assign w_p1Zero  = (r_p1Hp == 8'd0);
    assign w_p2Zero  = (r_p2Hp == 8'd0);
    assign w_anyZero = w_p1Zero || w_p2Zero;
    assign w_koEnter = (r_state == S_FIGHT) && w_anyZero;
    assign w_koDone  = (r_state == S_KO_HOLD) && (r_koCnt == L_KO_LAST);
    assign w_p1Hit   = (r_state == S_FIGHT) && !w_anyZero && hitP1 && (r_p1Stun == 8'd0);
    assign w_p2Hit   = (r_state == S_FIGHT) && !w_anyZero && hitP2 && (r_p2Stun == 8'd0);
    assign w_p1HpHit = (r_p1Hp > L_DAMAGE) ? (r_p1Hp - L_DAMAGE) : 8'd0;
    assign w_p2HpHit = (r_p2Hp > L_DAMAGE) ? (r_p2Hp - L_DAMAGE) : 8'd0;

    always_comb begin
        w_koWinner = 2'b00;
        if (w_p1Zero && w_p2Zero) begin
            w_koWinner = L_DOUBLE_KO_WINNER;
        end else if (w_p1Zero) begin
            w_koWinner = 2'b10;
        end else if (w_p2Zero) begin
            w_koWinner = 2'b01;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_stateNext = S_FIGHT;
                end
            end
            S_FIGHT: begin
                if (w_anyZero) begin
                    w_stateNext = S_KO_HOLD;
                end
            end
            S_KO_HOLD: begin
                if (w_koDone) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_stateNext = S_FIGHT;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_comb begin
        fighting   = 1'b0;
        ko         = 1'b0;
        round_over = 1'b0;
        case (r_state)
            S_FIGHT:   fighting   = 1'b1;
            S_KO_HOLD: ko         = 1'b1;
            S_DONE:    round_over = 1'b1;
            default:   fighting   = 1'b0;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_p1Hp <= L_MAX_HP;
            r_p2Hp <= L_MAX_HP;
        end else if (w_reload) begin
            r_p1Hp <= L_MAX_HP;
            r_p2Hp <= L_MAX_HP;
        end else begin
            if (w_p1Hit) begin
                r_p1Hp <= w_p1HpHit;
            end else if (w_koEnter && w_p1Zero && w_p2Zero && L_RESTORE_P1) begin
                r_p1Hp <= 8'd1;
            end
            if (w_p2Hit) begin
                r_p2Hp <= w_p2HpHit;
            end
        end
    end

    // Stun counters keep running down in every state so KO_HOLD does not freeze invulnerability.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_p1Stun <= 8'd0;
            r_p2Stun <= 8'd0;
        end else if (w_reload) begin
            r_p1Stun <= 8'd0;
            r_p2Stun <= 8'd0;
        end else begin
            if (w_p1Hit) begin
                r_p1Stun <= L_IFRAMES;
            end else if (r_p1Stun != 8'd0) begin
                r_p1Stun <= r_p1Stun - 8'd1;
            end
            if (w_p2Hit) begin
                r_p2Stun <= L_IFRAMES;
            end else if (r_p2Stun != 8'd0) begin
                r_p2Stun <= r_p2Stun - 8'd1;
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_koCnt <= 10'd0;
        end else if ((r_state == S_KO_HOLD) && !w_koDone) begin
            r_koCnt <= r_koCnt + 10'd1;
        end else begin
            r_koCnt <= 10'd0;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_winner <= 2'b00;
        end else if (w_reload) begin
            r_winner <= 2'b00;
        end else if (w_koEnter) begin
            r_winner <= w_koWinner;
        end
    end

    assign p1_hp   = r_p1Hp;
    assign p2_hp   = r_p2Hp;
    assign p1_stun = (r_p1Stun != 8'd0);
    assign p2_stun = (r_p2Stun != 8'd0);
    assign winner  = r_winner;

endmodule

// File: tb/tb_fight_health.sv
// Directed self-checking bench for fight_health: a default instance and a fast instance
// (DAMAGE=30, IFRAMES=2, KO_HOLD=4) for saturation, double KO and mid-KO reset.
module tb_fight_health;

    logic       frame_clk;
    logic       Reset;
    logic       start, hitP1, hitP2;
    logic [7:0] p1_hp, p2_hp;
    logic       p1_stun, p2_stun, fighting, ko, round_over;
    logic [1:0] winner;

    logic       bStart, bHitP1, bHitP2;
    logic [7:0] bP1Hp, bP2Hp;
    logic       bP1Stun, bP2Stun, bFighting, bKo, bRoundOver;
    logic [1:0] bWinner;

    int nChecks = 0;
    int nFails  = 0;

    fight_health u_dut (
        .frame_clk(frame_clk), .Reset(Reset), .start(start), .hitP1(hitP1), .hitP2(hitP2),
        .p1_hp(p1_hp), .p2_hp(p2_hp), .p1_stun(p1_stun), .p2_stun(p2_stun),
        .fighting(fighting), .ko(ko), .round_over(round_over), .winner(winner)
    );

    fight_health #(.MAX_HP(100), .DAMAGE(30), .IFRAMES(2), .KO_HOLD(4)) u_fast (
        .frame_clk(frame_clk), .Reset(Reset), .start(bStart), .hitP1(bHitP1), .hitP2(bHitP2),
        .p1_hp(bP1Hp), .p2_hp(bP2Hp), .p1_stun(bP1Stun), .p2_stun(bP2Stun),
        .fighting(bFighting), .ko(bKo), .round_over(bRoundOver), .winner(bWinner)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        nChecks++; if (p1_hp !== 8'd100) begin nFails++; $display("[TB] FAIL reset_p1_hp actual=%0d expected=100", p1_hp); end
        nChecks++; if (p2_hp !== 8'd100) begin nFails++; $display("[TB] FAIL reset_p2_hp actual=%0d expected=100", p2_hp); end
        nChecks++; if ({fighting, ko, round_over, p1_stun, p2_stun} !== 5'b0) begin nFails++; $display("[TB] FAIL reset_flags actual=%b expected=00000", {fighting, ko, round_over, p1_stun, p2_stun}); end
        nChecks++; if (winner !== 2'b00) begin nFails++; $display("[TB] FAIL reset_winner actual=%b expected=00", winner); end
        Reset = 1'b0;
        hitP1 = 1'b1;
        step();
        hitP1 = 1'b0;
        step();
        nChecks++; if ((fighting !== 1'b0) || (p1_hp !== 8'd100)) begin nFails++; $display("[TB] FAIL idle_hold actual=fighting %b hp %0d expected=fighting 0 hp 100", fighting, p1_hp); end
    endtask

    task automatic test_single_hit();
        int stunFrames;
        start = 1'b1;
        step();
        start = 1'b0;
        nChecks++; if ((fighting !== 1'b1) || (p1_hp !== 8'd100) || (p2_hp !== 8'd100)) begin nFails++; $display("[TB] FAIL start_fight actual=%b/%0d/%0d expected=1/100/100", fighting, p1_hp, p2_hp); end
        hitP2 = 1'b1;
        step();
        hitP2 = 1'b0;
        nChecks++; if (p2_hp !== 8'd90) begin nFails++; $display("[TB] FAIL hit_p2_hp actual=%0d expected=90", p2_hp); end
        nChecks++; if (p1_hp !== 8'd100) begin nFails++; $display("[TB] FAIL hit_p1_hp actual=%0d expected=100", p1_hp); end
        nChecks++; if ((p2_stun !== 1'b1) || (p1_stun !== 1'b0)) begin nFails++; $display("[TB] FAIL hit_stun actual=p1 %b p2 %b expected=p1 0 p2 1", p1_stun, p2_stun); end
        stunFrames = 1;
        for (int k = 1; k <= 40; k++) begin
            hitP2 = (k == 5);
            step();
            hitP2 = 1'b0;
            if (k == 5) begin
                nChecks++; if ((p2_hp !== 8'd90) || (p2_stun !== 1'b1)) begin nFails++; $display("[TB] FAIL stunned_hit actual=hp %0d stun %b expected=hp 90 stun 1", p2_hp, p2_stun); end
            end
            if (p2_stun === 1'b1) stunFrames++;
            else break;
        end
        nChecks++; if (stunFrames != 30) begin nFails++; $display("[TB] FAIL stun_frames actual=%0d expected=30", stunFrames); end
        hitP2 = 1'b1;
        step();
        hitP2 = 1'b0;
        nChecks++; if ((p2_hp !== 8'd80) || (p2_stun !== 1'b1)) begin nFails++; $display("[TB] FAIL rehit actual=hp %0d stun %b expected=hp 80 stun 1", p2_hp, p2_stun); end
    endtask

    task automatic test_ko();
        int koFrames;
        for (int i = 0; i < 10; i++) begin
            hitP1 = 1'b1;
            start = (i == 4);
            step();
            hitP1 = 1'b0;
            start = 1'b0;
            nChecks++; if (p1_hp !== 8'(90 - 10 * i)) begin nFails++; $display("[TB] FAIL ko_hit%0d actual=%0d expected=%0d", i, p1_hp, 90 - 10 * i); end
            if (i < 9) begin
                for (int w = 0; w < 40; w++) begin
                    if (p1_stun === 1'b0) break;
                    step();
                end
            end
        end
        nChecks++; if ((fighting !== 1'b1) || (ko !== 1'b0)) begin nFails++; $display("[TB] FAIL ko_latency actual=fighting %b ko %b expected=fighting 1 ko 0", fighting, ko); end
        step();
        nChecks++; if ((ko !== 1'b1) || (winner !== 2'b10) || (fighting !== 1'b0)) begin nFails++; $display("[TB] FAIL ko_enter actual=ko %b winner %b expected=ko 1 winner 10", ko, winner); end
        koFrames = 1;
        for (int k = 1; k <= 130; k++) begin
            start = (k == 3);
            hitP2 = (k == 5);
            step();
            start = 1'b0;
            hitP2 = 1'b0;
            if (ko === 1'b1) koFrames++;
            else break;
        end
        nChecks++; if (koFrames != 120) begin nFails++; $display("[TB] FAIL ko_frames actual=%0d expected=120", koFrames); end
        nChecks++; if ((round_over !== 1'b1) || (winner !== 2'b10)) begin nFails++; $display("[TB] FAIL done actual=round_over %b winner %b expected=1 10", round_over, winner); end
        nChecks++; if ((p1_hp !== 8'd0) || (p2_hp !== 8'd80)) begin nFails++; $display("[TB] FAIL ko_frozen actual=%0d/%0d expected=0/80", p1_hp, p2_hp); end
        step();
        step();
        nChecks++; if ((round_over !== 1'b1) || (p1_hp !== 8'd0)) begin nFails++; $display("[TB] FAIL done_hold actual=round_over %b hp %0d expected=1 0", round_over, p1_hp); end
        start = 1'b1;
        step();
        start = 1'b0;
        nChecks++; if ((p1_hp !== 8'd100) || (p2_hp !== 8'd100) || (fighting !== 1'b1) || (winner !== 2'b00)) begin nFails++; $display("[TB] FAIL restart actual=%0d/%0d f%b w%b expected=100/100 f1 w00", p1_hp, p2_hp, fighting, winner); end
    endtask

    task automatic test_saturate();
        int waitFrames;
        bStart = 1'b1;
        step();
        bStart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bHitP1 = 1'b1;
            step();
            bHitP1 = 1'b0;
            if (i == 2) begin
                nChecks++; if (bP1Hp !== 8'd10) begin nFails++; $display("[TB] FAIL sat_pre actual=%0d expected=10", bP1Hp); end
            end
            step();
            step();
        end
        nChecks++; if (bP1Hp !== 8'd0) begin nFails++; $display("[TB] FAIL sat_zero actual=%0d expected=0", bP1Hp); end
        nChecks++; if ((bKo !== 1'b1) || (bWinner !== 2'b10)) begin nFails++; $display("[TB] FAIL sat_ko actual=ko %b winner %b expected=ko 1 winner 10", bKo, bWinner); end
        waitFrames = 0;
        while ((bRoundOver !== 1'b1) && (waitFrames < 20)) begin
            step();
            waitFrames++;
        end
        nChecks++; if (bRoundOver !== 1'b1) begin nFails++; $display("[TB] FAIL sat_done actual=%b expected=1", bRoundOver); end
    endtask

    task automatic test_double_ko();
        bStart = 1'b1;
        step();
        bStart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bHitP1 = 1'b1;
            bHitP2 = 1'b1;
            step();
            bHitP1 = 1'b0;
            bHitP2 = 1'b0;
            if (i < 3) begin
                step();
                step();
            end
        end
        nChecks++; if ((bP1Hp !== 8'd0) || (bP2Hp !== 8'd0)) begin nFails++; $display("[TB] FAIL double_hit actual=%0d/%0d expected=0/0", bP1Hp, bP2Hp); end
        step();
`ifdef DRAW_EN
        nChecks++; if ((bWinner !== 2'b11) || (bP1Hp !== 8'd0) || (bKo !== 1'b1)) begin nFails++; $display("[TB] FAIL double_ko actual=w %b hp %0d ko %b expected=w 11 hp 0 ko 1", bWinner, bP1Hp, bKo); end
`else
        nChecks++; if ((bWinner !== 2'b01) || (bP1Hp !== 8'd1) || (bKo !== 1'b1)) begin nFails++; $display("[TB] FAIL double_ko actual=w %b hp %0d ko %b expected=w 01 hp 1 ko 1", bWinner, bP1Hp, bKo); end
`endif
        nChecks++; if (bP2Hp !== 8'd0) begin nFails++; $display("[TB] FAIL double_p2 actual=%0d expected=0", bP2Hp); end
    endtask

    task automatic test_reset_mid_ko();
        step();
        nChecks++; if (bKo !== 1'b1) begin nFails++; $display("[TB] FAIL midko_pre actual=%b expected=1", bKo); end
        #2;
        Reset = 1'b1;
        #1;
        nChecks++; if ((bP1Hp !== 8'd100) || (bP2Hp !== 8'd100) || (bWinner !== 2'b00)) begin nFails++; $display("[TB] FAIL async_reset_hp actual=%0d/%0d w %b expected=100/100 w 00", bP1Hp, bP2Hp, bWinner); end
        nChecks++; if ({bFighting, bKo, bRoundOver, bP1Stun, bP2Stun} !== 5'b0) begin nFails++; $display("[TB] FAIL async_reset_flags actual=%b expected=00000", {bFighting, bKo, bRoundOver, bP1Stun, bP2Stun}); end
        nChecks++; if ((fighting !== 1'b0) || (p1_hp !== 8'd100)) begin nFails++; $display("[TB] FAIL reset_mid_fight actual=f %b hp %0d expected=f 0 hp 100", fighting, p1_hp); end
        step();
        Reset = 1'b0;
        step();
        step();
        step();
        nChecks++; if ((bFighting !== 1'b0) || (bKo !== 1'b0) || (fighting !== 1'b0)) begin nFails++; $display("[TB] FAIL post_reset_idle actual=%b%b%b expected=000", bFighting, bKo, fighting); end
        bStart = 1'b1;
        step();
        bStart = 1'b0;
        nChecks++; if ((bFighting !== 1'b1) || (bP1Hp !== 8'd100)) begin nFails++; $display("[TB] FAIL post_reset_start actual=f %b hp %0d expected=f 1 hp 100", bFighting, bP1Hp); end
    endtask

    initial begin
        Reset  = 1'b1;
        start  = 1'b0;
        hitP1  = 1'b0;
        hitP2  = 1'b0;
        bStart = 1'b0;
        bHitP1 = 1'b0;
        bHitP2 = 1'b0;
        test_reset();
        test_single_hit();
        test_ko();
        test_saturate();
        test_double_ko();
        test_reset_mid_ko();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
